vga_pic_fetch_arb: RTL and testbench

Fetch controller and single-port arbiter for the picture block memory in the 1024x768 VGA path. It generates the row-major read addresses for a P_WIDTH x P_HEIGHT picture window at a configurable screen origin, and returns registered 12-bit pixels aligned to the pixel counters delayed by 2 cycles. The same memory port is shared with a host writer (keyboard/score updater) through a valid/ready handshake. Display fetch always has priority.

---
 rtl/vga_pic_fetch_arb_if.sv | 35 +++
 rtl/vga_pic_fetch_arb.sv | 144 ++++++++++++++
 tb/tb_vga_pic_fetch_arb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pic_fetch_arb_if.sv
// rtl/vga_pic_fetch_arb_if.sv - shared picture-memory port and host write handshake
//
// Purpose: bundles the single memory port and the host write request channel
//          of vga_pic_fetch_arb.
// Signals:
//   mem_addr/mem_we/mem_din  memory port driven by the arbiter
//   mem_dout                 memory read data, 1-cycle latency
//   wr_valid/wr_addr/wr_data host write request
//   wr_ready                 host write accepted this cycle
// Modports:
//   slave  - the arbiter (vga_pic_fetch_arb)
//   master - the environment: memory plus host writer
`timescale 1ns/1ps
interface vga_pic_fetch_arb_if #(
  parameter int AW = 16
);
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [11:0]   mem_din;
  logic [11:0]   mem_dout;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_dout,
    output wr_ready, mem_addr, mem_we, mem_din
  );

  modport master (
    output wr_valid, wr_addr, wr_data, mem_dout,
    input  wr_ready, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/vga_pic_fetch_arb.sv
// rtl/vga_pic_fetch_arb.sv - picture fetch controller and memory port arbiter
//
// Purpose: walks a P_WIDTH x P_HEIGHT picture window row-major at screen
//          origin (P_X, P_Y), returns pixels two clk_vga cycles after their
//          fetch, and lends idle memory cycles to a host writer. Display
//          fetch always wins the port.
// Ports:
//   clk_vga     65 MHz pixel clock
//   RST_N       asynchronous active-low reset
//   hcnt, vcnt  pixel / line counters
//   bus         memory port + host write handshake (slave modport)
//   pix_rgb     picture pixel, 0 outside the window
//   pix_in_win  pix_rgb carries picture data this cycle
//   frame_done  one-cycle pulse after the last picture pixel is fetched
// Build option: VGA_PIC_WRLOCK_EN restricts host writes to vertical blanking.
`timescale 1ns/1ps
module vga_pic_fetch_arb #(
  parameter int H_DISP   = 1024,
  parameter int V_DISP   = 768,
  parameter int P_X      = 412,
  parameter int P_Y      = 284,
  parameter int P_WIDTH  = 200,
  parameter int P_HEIGHT = 200,
  parameter int AW       = 16
) (
  input  logic                clk_vga,
  input  logic                RST_N,
  input  logic [10:0]         hcnt,
  input  logic [10:0]         vcnt,
  vga_pic_fetch_arb_if.slave  bus,
  output logic [11:0]         pix_rgb,
  output logic                pix_in_win,
  output logic                frame_done
);

  localparam logic [10:0]   H_LO    = 11'(P_X);
  localparam logic [10:0]   H_HI    = 11'(P_X + P_WIDTH);
  localparam logic [10:0]   V_LO    = 11'(P_Y);
  localparam logic [10:0]   V_HI    = 11'(P_Y + P_HEIGHT);
  localparam logic [10:0]   H_ACT   = 11'(H_DISP);
  localparam logic [10:0]   V_ACT   = 11'(V_DISP);
  localparam logic [AW-1:0] LAST_RD = AW'(P_WIDTH * P_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ROWS = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          done_d;
  logic          flag_q;
  logic [11:0]   pix_rgb_q;
  logic          pix_in_win_q;
  logic          frame_done_q;

  logic fetch_now;
  logic fetch_cyc;
  logic frame_start;
  logic grant_window;
  logic wr_grant;

  // The extra active-area terms only matter for misconfigured windows;
  // they keep the window from ever reaching into blanking.
  assign fetch_now = (vcnt >= V_LO) && (vcnt < V_HI) && (vcnt < V_ACT) &&
                     (hcnt >= H_LO) && (hcnt < H_HI) && (hcnt < H_ACT);
  assign frame_start = (vcnt == 11'd0) && (hcnt == 11'd0);
  // Window hits outside S_ROWS (e.g. after a mid-frame reset) are ignored.
  assign fetch_cyc = fetch_now && (state_q == S_ROWS);

`ifdef VGA_PIC_WRLOCK_EN
  assign grant_window = (vcnt >= V_ACT);
`else
  assign grant_window = 1'b1;
`endif

  // RST_N gates the grant so the memory port is quiet while in reset even
  // though the mux is purely combinational.
  assign wr_grant     = RST_N && bus.wr_valid && !fetch_now && grant_window;
  assign bus.wr_ready = wr_grant;
  assign bus.mem_we   = wr_grant;
  assign bus.mem_addr = wr_grant ? bus.wr_addr : rd_addr_q;
  assign bus.mem_din  = wr_grant ? bus.wr_data : 12'd0;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    if (frame_start) begin
      state_d   = S_WAIT;
      rd_addr_d = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if ((vcnt == V_LO) && (hcnt == 11'd0)) begin
            state_d = S_ROWS;
          end
        end
        S_ROWS: begin
          if (fetch_now) begin
            // The address parks on the last pixel instead of wrapping.
            if (rd_addr_q == LAST_RD) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              rd_addr_d = rd_addr_q + AW'(1);
            end
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_WAIT;
      rd_addr_q    <= '0;
      flag_q       <= 1'b0;
      pix_rgb_q    <= 12'd0;
      pix_in_win_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      // Stage 1 tracks the memory's read latency; stage 2 lands the data.
      flag_q       <= fetch_cyc;
      pix_rgb_q    <= flag_q ? bus.mem_dout : 12'd0;
      pix_in_win_q <= flag_q;
      frame_done_q <= done_d;
    end
  end

  assign pix_rgb    = pix_rgb_q;
  assign pix_in_win = pix_in_win_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_pic_fetch_arb.sv
// tb/tb_vga_pic_fetch_arb.sv - scoreboard bench for vga_pic_fetch_arb
`timescale 1ns/1ps
module tb_vga_pic_fetch_arb;
  localparam int AW = 16;

  logic        clk_vga = 1'b0;
  logic        RST_N   = 1'b0;
  logic [10:0] hcnt    = 11'd0;
  logic [10:0] vcnt    = 11'd0;
  logic [11:0] pix_rgb;
  logic        pix_in_win;
  logic        frame_done;

  vga_pic_fetch_arb_if #(.AW(AW)) bus ();

  vga_pic_fetch_arb #(.AW(AW)) dut (
    .clk_vga    (clk_vga),
    .RST_N      (RST_N),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .bus        (bus),
    .pix_rgb    (pix_rgb),
    .pix_in_win (pix_in_win),
    .frame_done (frame_done)
  );

  always #5 clk_vga = ~clk_vga;

  // Memory model: read data equals the low 12 address bits, 1-cycle latency.
  always @(posedge clk_vga) bus.mem_dout <= bus.mem_addr[11:0];

  typedef struct { logic [11:0] data; int h; int v; } pix_exp_t;
  typedef struct { logic [15:0] addr; logic [11:0] data; int h; int v; } wr_exp_t;
  typedef struct { int h; int v; } pos_t;

  pix_exp_t pix_q[$];
  wr_exp_t  wr_q[$];
  pos_t     fd_q[$];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int wr_base = 0;
  int pix_seen = 0;
  bit hold_wr = 1'b0;
  logic [11:0] last_pix = 12'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (hcnt=%0d vcnt=%0d t=%0t)",
               name, act, exp, hcnt, vcnt, $time);
    end
  endtask

  function automatic bit in_win(input int h, input int v);
    return (v >= 284) && (v < 484) && (h >= 412) && (h < 612);
  endfunction

  function automatic bit exp_ready();
    bit gw;
`ifdef VGA_PIC_WRLOCK_EN
    gw = (vcnt >= 11'd768);
`else
    gw = 1'b1;
`endif
    return RST_N && bus.wr_valid && !in_win(int'(hcnt), int'(vcnt)) && gw;
  endfunction

  // Monitor: pops and compares whenever the DUT presents an output.
  always @(negedge clk_vga) begin
    pix_exp_t pe;
    wr_exp_t  we;
    pos_t     fp;
    if (pix_in_win) begin
      if (pix_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pix_extra: got pix 0x%0h expected none (hcnt=%0d vcnt=%0d)", pix_rgb, hcnt, vcnt);
      end else begin
        pe = pix_q.pop_front();
        check("pix_data", pix_rgb, pe.data);
        check("pix_h", hcnt, pe.h);
        check("pix_v", vcnt, pe.v);
        pix_seen++;
        last_pix = pix_rgb;
      end
    end else begin
      check("pix_zero", pix_rgb, 0);
    end
    if (bus.wr_valid) check("wr_ready", bus.wr_ready, exp_ready());
    else              check("we_idle", bus.mem_we, 0);
    if (bus.mem_we) begin
      wr_seen++;
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_extra: got write 0x%0h expected none", bus.mem_addr);
      end else begin
        we = wr_q.pop_front();
        check("wr_addr", bus.mem_addr, we.addr);
        check("wr_data", bus.mem_din, we.data);
        check("wr_h", hcnt, we.h);
        check("wr_v", vcnt, we.v);
      end
    end
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fd_extra: got frame_done 1 expected 0 (hcnt=%0d vcnt=%0d)", hcnt, vcnt);
      end else begin
        fp = fd_q.pop_front();
        check("fd_h", hcnt, fp.h);
        check("fd_v", vcnt, fp.v);
      end
    end
  end

  // One pixel-clock cycle at (h, v); directed pixel checks at the window edges.
  task automatic drive(input int h, input int v);
    hcnt = 11'(h);
    vcnt = 11'(v);
    @(negedge clk_vga);
    if (v == 284 && h == 413) check("pix_before_first", {pix_in_win, pix_rgb}, 13'h0000);
    if (v == 284 && h == 414) check("pix_first",  {pix_in_win, pix_rgb}, 13'h1000);
    if (v == 284 && h == 415) check("pix_second", {pix_in_win, pix_rgb}, 13'h1001);
    if (v == 284 && h == 614) check("pix_after_row", {pix_in_win, pix_rgb}, 13'h0000);
    @(posedge clk_vga);
    #1;
    if (hold_wr && wr_seen != wr_base) begin
      bus.wr_valid = 1'b0;
      hold_wr = 1'b0;
    end
  endtask

  task automatic full_frame(input bit with_write);
    pix_exp_t pe;
    wr_exp_t  we;
    pos_t     fp;
    pix_seen = 0;
    fp.h = 612; fp.v = 483;
    fd_q.push_back(fp);
    drive(0, 0);
    drive(0, 284);
    for (int v = 284; v < 484; v++) begin
      for (int h = 410; h <= 614; h++) begin
        if (in_win(h, v)) begin
          pe.data = 12'((v - 284) * 200 + (h - 412));
          pe.h = h + 2;
          pe.v = v;
          pix_q.push_back(pe);
        end
        if (with_write && v == 300 && h == 500) begin
          bus.wr_addr  = 16'h0100;
          bus.wr_data  = 12'hABC;
          bus.wr_valid = 1'b1;
          wr_base = wr_seen;
          hold_wr = 1'b1;
          we.addr = 16'h0100;
          we.data = 12'hABC;
`ifdef VGA_PIC_WRLOCK_EN
          we.h = 0;   we.v = 768;
`else
          we.h = 612; we.v = 300;
`endif
          wr_q.push_back(we);
        end
        drive(h, v);
      end
    end
    check("frame_fetches", pix_seen, 40000);
    check("frame_last_pix", last_pix, 12'hC3F);
  endtask

  initial begin
    wr_exp_t we;
    pix_exp_t pe;

    // Reset state with a write request pending in blanking.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 16'h1234;
    bus.wr_data  = 12'hFFF;
    hcnt = 11'd0;
    vcnt = 11'd770;
    #12;
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_din", bus.mem_din, 0);
    check("rst_pix_rgb", pix_rgb, 0);
    check("rst_pix_in_win", pix_in_win, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_frame_done", frame_done, 0);
    bus.wr_valid = 1'b0;
    @(posedge clk_vga);
    #1;
    RST_N = 1'b1;

    // Frame 1 with a held host write in row 300.
    full_frame(1'b1);
    drive(0, 768);
    drive(1, 768);
    check("wr_once", wr_seen - wr_base, 1);
    check("wr_released", bus.wr_valid, 0);

    // Back-to-back writes in vertical blanking.
    wr_base = wr_seen;
    for (int i = 0; i < 8; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 16'(16'h0200 + i * 16'h0011);
      bus.wr_data  = 12'(12'h5A0 + i * 3);
      we.addr = bus.wr_addr;
      we.data = bus.wr_data;
      we.h = i;
      we.v = 770;
      wr_q.push_back(we);
      drive(i, 770);
    end
    bus.wr_valid = 1'b0;
    drive(8, 770);
    check("b2b_count", wr_seen - wr_base, 8);

    // Frame 2: fetch part of row 350 then reset mid-row.
    drive(0, 0);
    drive(0, 284);
    for (int h = 410; h < 450; h++) begin
      if (h >= 412 && h < 448) begin
        pe.data = 12'(h - 412);
        pe.h = h + 2;
        pe.v = 350;
        pix_q.push_back(pe);
      end
      drive(h, 350);
    end
    hcnt = 11'd450;
    RST_N = 1'b0;
    #1;
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_pix", {pix_in_win, pix_rgb}, 13'h0000);
    check("mid_rst_mem_we", bus.mem_we, 0);
    check("mid_rst_frame_done", frame_done, 0);
    @(posedge clk_vga);
    #1;
    drive(451, 350);
    RST_N = 1'b1;
    for (int h = 452; h <= 614; h++) drive(h, 350);
    for (int h = 410; h <= 614; h++) drive(h, 351);

    // Frame 3 must restart at address 0 and fetch the whole picture.
    full_frame(1'b0);
    drive(0, 484);

    check("pix_q_empty", pix_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("fd_q_empty", fd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
